// File: rtl/ram_nit_unpacker.sv
// ram_nit_unpacker: reads program RAM words and serializes each into color nits, MS pair first.
module ram_nit_unpacker #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 12,
    parameter int NIT_WIDTH     = 2,
    parameter int NITS_PER_WORD = DATA_WIDTH / NIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] lastAddress,
    output logic [ADDR_WIDTH-1:0] ramReadAddress,
    input  logic [DATA_WIDTH-1:0] ramReadData,
    output logic                  nitValid,
    output logic [NIT_WIDTH-1:0]  nit,
    input  logic                  nitReady,
    output logic [ADDR_WIDTH-1:0] wordAddress,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_DONE} state_t;
    localparam logic [2:0] LAST_NIT = 3'(NITS_PER_WORD - 1);
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_last;
    logic                  w_fire, w_last_nit, w_last_word;
    assign w_fire      = (r_state == S_SEND) && nitReady;
    assign w_last_nit  = r_count == LAST_NIT;
    assign w_last_word = ramReadAddress == r_last;
    assign nitValid    = r_state == S_SEND;
    assign nit         = r_shift[DATA_WIDTH-1 -: NIT_WIDTH];
    assign busy        = r_state != S_IDLE;
    assign done        = r_state == S_DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND:  w_next = (w_fire && w_last_nit) ? (w_last_word ? S_DONE : S_FETCH) : S_SEND;
            default: w_next = S_IDLE;
        endcase
    end
    // The read address only advances between words, so it never wraps past the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramReadAddress <= '0;
            wordAddress    <= '0;
            r_shift        <= '0;
            r_count        <= '0;
            r_last         <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_last         <= lastAddress;
            ramReadAddress <= '0;
        end else if (r_state == S_LOAD) begin
            r_shift     <= ramReadData;
            r_count     <= '0;
            wordAddress <= ramReadAddress;
        end else if (w_fire) begin
            r_shift <= r_shift << NIT_WIDTH;
            r_count <= r_count + 3'd1;
            if (w_last_nit && !w_last_word) ramReadAddress <= ramReadAddress + 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_nit_unpacker.sv
// tb_ram_nit_unpacker: table-driven dumps with a nit scoreboard plus reset/restart corner sequences.
module tb_ram_nit_unpacker;
    logic        clk = 0, reset = 1, start = 0, nitReady = 0;
    logic [7:0]  lastAddress = 0, ramReadAddress, wordAddress;
    logic [11:0] ramReadData;
    logic        nitValid, busy, done;
    logic [1:0]  nit;
    logic [11:0] mem [256];

    ram_nit_unpacker dut (
        .clk(clk), .reset(reset), .start(start), .lastAddress(lastAddress),
        .ramReadAddress(ramReadAddress), .ramReadData(ramReadData),
        .nitValid(nitValid), .nit(nit), .nitReady(nitReady),
        .wordAddress(wordAddress), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ramReadData <= mem[ramReadAddress];

    typedef struct { logic [1:0] nit; logic [7:0] waddr; } exp_t;
    typedef struct {
        logic [7:0] last; int mode; int fill;
        logic [11:0] w0, w1, w2;
        int exp_nits; logic [11:0] tail; bit chk_tail;
    } vec_t;

    exp_t exp_q[$];
    int checks = 0, failures = 0;
    int cycle = 0, last_hs = -10, hs = 0, dones = 0, gap = 0;
    logic hold_prev = 0, valid_prev = 0;
    logic [1:0] held_nit = 0;
    logic [11:0] tail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (hold_prev) chk("hold_stable", {nitValid, nit}, {1'b1, held_nit});
        hold_prev = nitValid && !nitReady;
        held_nit  = nit;
        if (nitValid && !valid_prev) chk("gap_before_word", gap, 2);
        gap = (busy && !nitValid) ? gap + 1 : 0;
        valid_prev = nitValid;
        if (nitValid && nitReady) begin
            hs++;
            last_hs = cycle;
            tail = {tail[9:0], nit};
            if (exp_q.size() == 0) chk("extra_nit", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("nit", nit, e.nit);
                chk("word_addr", wordAddress, e.waddr);
            end
        end
        if (done) begin
            dones++;
            chk("done_timing", cycle, last_hs + 1);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cycle++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int last);
        exp_t e;
        for (int a = 0; a <= last; a++)
            for (int k = 0; k < 6; k++) begin
                e.nit   = 2'((mem[a] >> (10 - 2 * k)) & 12'h3);
                e.waddr = 8'(a);
                exp_q.push_back(e);
            end
    endtask

    task automatic fill_mem(input vec_t v);
        for (int n = 0; n < 256; n++)
            mem[n] = (v.fill == 1) ? 12'(n) : (v.fill == 2) ? 12'($urandom) : 12'h0;
        if (v.fill == 0) begin
            mem[0] = v.w0; mem[1] = v.w1; mem[2] = v.w2;
        end
    endtask

    function automatic logic rdy(input int mode, input int i);
        return (mode == 0) ? 1'b1 : (mode == 1) ? (i % 3 == 0) : 1'($urandom_range(0, 1));
    endfunction

    task automatic run_dump(input vec_t v);
        fill_mem(v);
        exp_q.delete();
        push_words(v.last);
        dones = 0; hs = 0;
        lastAddress = v.last; start = 1; nitReady = rdy(v.mode, 0);
        cyc();
        start = 0;
        for (int i = 1; i < v.exp_nits * 4 + 40 && dones == 0; i++) begin
            nitReady = rdy(v.mode, i);
            cyc();
        end
        chk("done_seen", dones, 1);
        chk("handshakes", hs, v.exp_nits);
        chk("queue_empty", exp_q.size(), 0);
        if (v.chk_tail) chk("last_word_nits", tail, v.tail);
        chk("final_read_addr", ramReadAddress, v.last);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        exp_q.delete();
    endtask

    vec_t vecs [5];
    vec_t v;

    initial begin
        vecs[0] = '{last: 8'd0,   mode: 0, fill: 0, w0: 12'h1B6, w1: 12'h0,   w2: 12'h0,   exp_nits: 6,    tail: 12'h1B6, chk_tail: 1};
        vecs[1] = '{last: 8'd0,   mode: 1, fill: 0, w0: 12'hE4C, w1: 12'h0,   w2: 12'h0,   exp_nits: 6,    tail: 12'hE4C, chk_tail: 1};
        vecs[2] = '{last: 8'd2,   mode: 0, fill: 0, w0: 12'hFFF, w1: 12'h000, w2: 12'h555, exp_nits: 18,   tail: 12'h555, chk_tail: 1};
        vecs[3] = '{last: 8'd255, mode: 0, fill: 1, w0: 12'h0,   w1: 12'h0,   w2: 12'h0,   exp_nits: 1536, tail: 12'h0FF, chk_tail: 1};
        vecs[4] = '{last: 8'd7,   mode: 2, fill: 2, w0: 12'h0,   w1: 12'h0,   w2: 12'h0,   exp_nits: 48,   tail: 12'h0,   chk_tail: 0};
        for (int n = 0; n < 256; n++) mem[n] = 12'h0;
        #1;
        chk("rst_valid", nitValid, 0);
        chk("rst_nit", nit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_raddr", ramReadAddress, 0);
        chk("rst_waddr", wordAddress, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        for (int r = 0; r < 5; r++) run_dump(vecs[r]);

        // start pulsed and lastAddress changed mid-dump
        v = vecs[3]; v.last = 3;
        fill_mem(v); exp_q.delete(); push_words(3);
        dones = 0; hs = 0; nitReady = 1;
        lastAddress = 3; start = 1;
        cyc();
        start = 0;
        for (int i = 1; i < 200 && dones == 0; i++) begin
            start = (i == 5 || i == 6);
            lastAddress = (i >= 5) ? 8'd10 : 8'd3;
            cyc();
        end
        start = 0;
        chk("busy_start_done", dones, 1);
        chk("busy_start_hs", hs, 24);
        chk("busy_start_raddr", ramReadAddress, 3);
        chk("busy_start_idle", busy, 0);

        // start held high through DONE restarts one cycle after the pulse
        v = vecs[0];
        fill_mem(v); exp_q.delete(); push_words(0); push_words(0);
        dones = 0; hs = 0; nitReady = 1;
        lastAddress = 0; start = 1;
        for (int i = 0; i < 40 && dones == 0; i++) cyc();
        chk("held_first_done", dones, 1);
        chk("held_idle_gap", busy, 0);
        cyc();
        chk("held_restart", busy, 1);
        start = 0;
        for (int i = 0; i < 40 && dones < 2; i++) cyc();
        chk("held_second_done", dones, 2);
        chk("held_hs", hs, 12);
        chk("held_queue", exp_q.size(), 0);

        // reset during 3rd nit of word 1
        v = vecs[3];
        fill_mem(v); exp_q.delete(); push_words(3);
        dones = 0; hs = 0; nitReady = 1;
        lastAddress = 3; start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 100 && hs < 8; i++) cyc();
        chk("reach_word1_nit3", hs, 8);
        chk("mid_valid", nitValid, 1);
        chk("mid_waddr", wordAddress, 1);
        reset = 1;
        #1;
        chk("mid_rst_valid", nitValid, 0);
        chk("mid_rst_nit", nit, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_raddr", ramReadAddress, 0);
        chk("mid_rst_waddr", wordAddress, 0);
        exp_q.delete();
        cyc();
        cyc();
        chk("mid_rst_no_done", dones, 0);
        reset = 0;
        v.last = 1; v.exp_nits = 12; v.tail = 12'h001;
        run_dump(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
